// File: rtl/stack_down_oob_rx_pkg.sv
// Shared encodings for the manager-to-stack downstream OOB channel:
// cntl delineators, packet type, error codes, header fields and FSM states.
package stack_down_oob_pkg;

  localparam logic [1:0] CNTL_SOM_EOM = 2'd0;
  localparam logic [1:0] CNTL_SOM     = 2'd1;
  localparam logic [1:0] CNTL_MOM     = 2'd2;
  localparam logic [1:0] CNTL_EOM     = 2'd3;

  localparam logic [1:0] TYPE_CONFIG  = 2'd0;

  localparam logic [1:0] ERR_OVERFLOW = 2'd0;
  localparam logic [1:0] ERR_COUNT    = 2'd1;
  localparam logic [1:0] ERR_ORPHAN   = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  localparam int HDR_N_LSB   = 0;
  localparam int HDR_N_W     = 8;
  localparam int HDR_CMD_LSB = 8;
  localparam int HDR_CMD_W   = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_PRESENT = 2'd3;

  typedef struct packed {
    logic [HDR_CMD_W-1:0] cmd;
    logic [HDR_N_W-1:0]   n;
  } hdr_t;

endpackage

// File: rtl/stack_down_oob_rx_if.sv
// Downstream OOB word channel from the manager; master = manager, slave = stack receiver.
interface stack_down_oob_rx_if #(
  parameter int DATA_W = 32,
  parameter int TYPE_W = 2,
  parameter int CNTL_W = 2
) ();

  logic [CNTL_W-1:0] mgr__std__oob_cntl;
  logic              mgr__std__oob_valid;
  logic              std__mgr__oob_ready;
  logic [TYPE_W-1:0] mgr__std__oob_type;
  logic [DATA_W-1:0] mgr__std__oob_data;

  modport master (
    output mgr__std__oob_cntl,
    output mgr__std__oob_valid,
    input  std__mgr__oob_ready,
    output mgr__std__oob_type,
    output mgr__std__oob_data
  );

  modport slave (
    input  mgr__std__oob_cntl,
    input  mgr__std__oob_valid,
    output std__mgr__oob_ready,
    input  mgr__std__oob_type,
    input  mgr__std__oob_data
  );

endinterface

// File: rtl/stack_down_oob_rx_tuple_store.sv
// Option-tuple register array: cleared on reset or header, written one slot per tuple word.
module stack_down_oob_tuple_store #(
  parameter int MAX_TUPLES = 8,
  parameter int OPT_TYPE_W = 8,
  parameter int OPT_VAL_W  = 24,
  parameter int IDX_W      = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear,
  input  logic                             we,
  input  logic [IDX_W-1:0]                 idx,
  input  logic [OPT_TYPE_W-1:0]            wr_type,
  input  logic [OPT_VAL_W-1:0]             wr_value,
  output logic [MAX_TUPLES*OPT_TYPE_W-1:0] opt_type,
  output logic [MAX_TUPLES*OPT_VAL_W-1:0]  opt_value
);

  logic [OPT_TYPE_W-1:0] type_q  [MAX_TUPLES];
  logic [OPT_VAL_W-1:0]  value_q [MAX_TUPLES];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < MAX_TUPLES; i++) begin
        type_q[i]  <= '0;
        value_q[i] <= '0;
      end
    end else if (we) begin
      type_q[idx]  <= wr_type;
      value_q[idx] <= wr_value;
    end
  end

  for (genvar g = 0; g < MAX_TUPLES; g++) begin : g_flat
    assign opt_type[g*OPT_TYPE_W +: OPT_TYPE_W] = type_q[g];
    assign opt_value[g*OPT_VAL_W +: OPT_VAL_W]  = value_q[g];
  end

endmodule

// File: rtl/stack_down_oob_rx.sv
// Stack-side receiver for the manager's downstream OOB channel: assembles header plus
// option tuples into one PE configuration record and hands it over on a valid/ready port.
//
// state    | meaning
// IDLE     | waiting for a header word
// COLLECT  | CONFIG header seen, storing tuples until EOM
// DISCARD  | swallowing the rest of a rejected packet until EOM
// PRESENT  | record offered to the PE array, manager stalled
module stack_down_oob_rx
  import stack_down_oob_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int TYPE_W     = 2,
  parameter int CNTL_W     = 2,
  parameter int MAX_TUPLES = 8,
  parameter int OPT_TYPE_W = 8,
  parameter int OPT_VAL_W  = 24
) (
  input  logic                             clk,
  input  logic                             reset_poweron,
  stack_down_oob_rx_if.slave               oob,
  output logic                             oob__pe__valid,
  input  logic                             pe__oob__ready,
  output logic [7:0]                       oob__pe__cmd,
  output logic [3:0]                       oob__pe__num_tuples,
  output logic [MAX_TUPLES*OPT_TYPE_W-1:0] oob__pe__opt_type,
  output logic [MAX_TUPLES*OPT_VAL_W-1:0]  oob__pe__opt_value,
  output logic                             oob__sys__error,
  output logic [1:0]                       oob__sys__err_code,
  output logic [7:0]                       oob__sys__drop_cnt
);

  localparam int SIDX_W = (MAX_TUPLES > 1) ? $clog2(MAX_TUPLES) : 1;
  localparam logic [CNTL_W-1:0] C_SOM_EOM = CNTL_W'(CNTL_SOM_EOM);
  localparam logic [CNTL_W-1:0] C_SOM     = CNTL_W'(CNTL_SOM);
  localparam logic [CNTL_W-1:0] C_EOM     = CNTL_W'(CNTL_EOM);
  localparam logic [TYPE_W-1:0] T_CONFIG  = TYPE_W'(TYPE_CONFIG);

  logic [1:0] state_q, state_nxt;
  logic [7:0] cmd_q, cmd_nxt;
  logic [7:0] n_q, n_nxt;
  logic [3:0] idx_q, idx_nxt;
  logic       rdy_q;
  logic       error_q, err_set;
  logic [1:0] err_code_q, err_code_nxt;
  logic [7:0] drop_q, drop_nxt;
  logic [1:0] drop_inc;
  logic [8:0] drop_sum;
  logic       accept, hdr_word, is_eom, is_config, start_hdr;
  logic       st_clear, st_we;
  hdr_t       hdr;

  assign accept    = oob.mgr__std__oob_valid && rdy_q;
  assign hdr_word  = (oob.mgr__std__oob_cntl == C_SOM) || (oob.mgr__std__oob_cntl == C_SOM_EOM);
  assign is_eom    = (oob.mgr__std__oob_cntl == C_EOM);
  assign is_config = (oob.mgr__std__oob_type == T_CONFIG);
  assign hdr.cmd   = oob.mgr__std__oob_data[HDR_CMD_LSB +: HDR_CMD_W];
  assign hdr.n     = oob.mgr__std__oob_data[HDR_N_LSB +: HDR_N_W];

  always_comb begin
    state_nxt    = state_q;
    cmd_nxt      = cmd_q;
    n_nxt        = n_q;
    idx_nxt      = idx_q;
    err_set      = 1'b0;
    err_code_nxt = err_code_q;
    drop_inc     = 2'd0;
    st_clear     = 1'b0;
    st_we        = 1'b0;
    start_hdr    = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (hdr_word) begin
            start_hdr = 1'b1;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_ORPHAN;
          end
        end
        ST_COLLECT: begin
          if (hdr_word) begin
            err_set      = 1'b1;
            err_code_nxt = ERR_ABORT;
            drop_inc     = 2'd1;
            start_hdr    = 1'b1;
          end else if (idx_q == 4'(MAX_TUPLES)) begin
            // an overflowing EOM already ends the packet, so nothing is left to discard
            err_set      = 1'b1;
            err_code_nxt = ERR_OVERFLOW;
            drop_inc     = 2'd1;
            state_nxt    = is_eom ? ST_IDLE : ST_DISCARD;
          end else begin
            st_we   = 1'b1;
            idx_nxt = idx_q + 4'd1;
            if (is_eom) begin
              if ({4'd0, idx_q + 4'd1} == n_q) begin
                state_nxt = ST_PRESENT;
              end else begin
                err_set      = 1'b1;
                err_code_nxt = ERR_COUNT;
                drop_inc     = 2'd1;
                state_nxt    = ST_IDLE;
              end
            end
          end
        end
        ST_DISCARD: begin
          if (is_eom) state_nxt = ST_IDLE;
        end
        default: ;
      endcase

      // header handling is shared by IDLE and the abort path out of COLLECT
      if (start_hdr) begin
        if (is_config) begin
          st_clear = 1'b1;
          cmd_nxt  = hdr.cmd;
          n_nxt    = hdr.n;
          idx_nxt  = 4'd0;
          if (oob.mgr__std__oob_cntl == C_SOM) begin
            state_nxt = ST_COLLECT;
          end else if (hdr.n == 8'd0) begin
            state_nxt = ST_PRESENT;
          end else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_COUNT;
            drop_inc     = drop_inc + 2'd1;
            state_nxt    = ST_IDLE;
          end
        end else begin
          drop_inc  = drop_inc + 2'd1;
          state_nxt = (oob.mgr__std__oob_cntl == C_SOM) ? ST_DISCARD : ST_IDLE;
        end
      end
    end else if (state_q == ST_PRESENT && pe__oob__ready) begin
      state_nxt = ST_IDLE;
    end
  end

  assign drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
  assign drop_nxt = drop_sum[8] ? 8'hFF : drop_sum[7:0];

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state_q    <= ST_IDLE;
      cmd_q      <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      rdy_q      <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_nxt;
      cmd_q      <= cmd_nxt;
      n_q        <= n_nxt;
      idx_q      <= idx_nxt;
      rdy_q      <= (state_nxt != ST_PRESENT);
      error_q    <= err_set;
      err_code_q <= err_code_nxt;
      drop_q     <= drop_nxt;
    end
  end

  stack_down_oob_tuple_store #(
    .MAX_TUPLES (MAX_TUPLES),
    .OPT_TYPE_W (OPT_TYPE_W),
    .OPT_VAL_W  (OPT_VAL_W),
    .IDX_W      (SIDX_W)
  ) u_tuple_store (
    .clk       (clk),
    .reset     (reset_poweron),
    .clear     (st_clear),
    .we        (st_we),
    .idx       (idx_q[SIDX_W-1:0]),
    .wr_type   (oob.mgr__std__oob_data[DATA_W-1 -: OPT_TYPE_W]),
    .wr_value  (oob.mgr__std__oob_data[OPT_VAL_W-1:0]),
    .opt_type  (oob__pe__opt_type),
    .opt_value (oob__pe__opt_value)
  );

  assign oob.std__mgr__oob_ready = rdy_q;
  assign oob__pe__valid          = (state_q == ST_PRESENT);
  assign oob__pe__cmd            = cmd_q;
  assign oob__pe__num_tuples     = idx_q;
  assign oob__sys__error         = error_q;
  assign oob__sys__err_code      = err_code_q;
  assign oob__sys__drop_cnt      = drop_q;

endmodule

// File: tb/tb_stack_down_oob_rx.sv
// Directed bench for stack_down_oob_rx: a vector table for single-word error/drop
// behaviour plus hand-written sequences for record hand-off, back-pressure, abort and reset.
module tb_stack_down_oob_rx;
  import stack_down_oob_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_poweron;
  logic         pe_valid;
  logic         pe_ready;
  logic [7:0]   pe_cmd;
  logic [3:0]   pe_num;
  logic [63:0]  pe_opt_type;
  logic [191:0] pe_opt_value;
  logic         sys_error;
  logic [1:0]   sys_err_code;
  logic [7:0]   sys_drop_cnt;

  stack_down_oob_rx_if bus ();

  stack_down_oob_rx dut (
    .clk                 (clk),
    .reset_poweron       (reset_poweron),
    .oob                 (bus),
    .oob__pe__valid      (pe_valid),
    .pe__oob__ready      (pe_ready),
    .oob__pe__cmd        (pe_cmd),
    .oob__pe__num_tuples (pe_num),
    .oob__pe__opt_type   (pe_opt_type),
    .oob__pe__opt_value  (pe_opt_value),
    .oob__sys__error     (sys_error),
    .oob__sys__err_code  (sys_err_code),
    .oob__sys__drop_cnt  (sys_drop_cnt)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [1:0]  cntl;
    logic [1:0]  typ;
    logic [31:0] data;
    logic        exp_err;
    logic [1:0]  exp_code;
    logic [7:0]  exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] c, input logic [1:0] t, input logic [31:0] d,
                     input logic e, input logic [1:0] code, input logic [7:0] drop);
    vec_t v;
    v.cntl = c; v.typ = t; v.data = d;
    v.exp_err = e; v.exp_code = code; v.exp_drop = drop;
    vecs.push_back(v);
  endtask

  // called at a negedge; returns at the negedge after the word has transferred
  task automatic send(input logic [1:0] c, input logic [1:0] t, input logic [31:0] d);
    int waited = 0;
    bus.mgr__std__oob_cntl  = c;
    bus.mgr__std__oob_type  = t;
    bus.mgr__std__oob_data  = d;
    bus.mgr__std__oob_valid = 1'b1;
    while (!bus.std__mgr__oob_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.std__mgr__oob_ready) begin
      tests++;
      failed++;
      $display("FAIL send_timeout: ready got 0 expected 1 after %0d cycles", waited);
    end
    @(negedge clk);
    bus.mgr__std__oob_valid = 1'b0;
  endtask

  task automatic ack(input string name);
    pe_ready = 1'b1;
    @(negedge clk);
    pe_ready = 1'b0;
    check({name, "_valid_drop"}, 256'(pe_valid), 256'(0));
    check({name, "_ready_back"}, 256'(bus.std__mgr__oob_ready), 256'(1));
  endtask

  logic [63:0]  exp_type;
  logic [191:0] exp_val;

  initial begin
    bus.mgr__std__oob_valid = 1'b0;
    bus.mgr__std__oob_cntl  = CNTL_SOM_EOM;
    bus.mgr__std__oob_type  = TYPE_CONFIG;
    bus.mgr__std__oob_data  = '0;
    pe_ready      = 1'b0;
    reset_poweron = 1'b1;

    // single-word behaviour: error pulse, held error code, drop counter
    add(CNTL_SOM,     2'd0, 32'h0000_5A03, 1'b0, 2'd0, 8'd0);
    add(CNTL_MOM,     2'd0, 32'h0100_0010, 1'b0, 2'd0, 8'd0);
    add(CNTL_MOM,     2'd0, 32'h0200_0020, 1'b0, 2'd0, 8'd0);
    add(CNTL_MOM,     2'd0, 32'h0300_0030, 1'b0, 2'd0, 8'd0);
    add(CNTL_EOM,     2'd0, 32'h0400_0040, 1'b1, ERR_COUNT, 8'd1);
    add(CNTL_MOM,     2'd0, 32'h0000_0000, 1'b1, ERR_ORPHAN, 8'd1);
    add(CNTL_EOM,     2'd0, 32'h0000_0000, 1'b1, ERR_ORPHAN, 8'd1);
    add(CNTL_SOM,     2'd1, 32'h0000_0001, 1'b0, ERR_ORPHAN, 8'd2);
    add(CNTL_MOM,     2'd0, 32'h0500_0050, 1'b0, ERR_ORPHAN, 8'd2);
    add(CNTL_EOM,     2'd0, 32'h0600_0060, 1'b0, ERR_ORPHAN, 8'd2);
    add(CNTL_SOM_EOM, 2'd0, 32'h0000_0002, 1'b1, ERR_COUNT, 8'd3);
    add(CNTL_SOM,     2'd0, 32'h0000_1109, 1'b0, ERR_COUNT, 8'd3);
    for (int i = 0; i < 8; i++)
      add(CNTL_MOM, 2'd0, {8'(i + 1), 24'(i)}, 1'b0, ERR_COUNT, 8'd3);
    add(CNTL_MOM,     2'd0, 32'h0900_0009, 1'b1, ERR_OVERFLOW, 8'd4);
    add(CNTL_MOM,     2'd0, 32'h0A00_000A, 1'b0, ERR_OVERFLOW, 8'd4);
    add(CNTL_EOM,     2'd0, 32'h0B00_000B, 1'b0, ERR_OVERFLOW, 8'd4);
    add(CNTL_SOM_EOM, 2'd2, 32'h0000_0000, 1'b0, ERR_OVERFLOW, 8'd5);

    repeat (3) @(negedge clk);
    check("rst_ready",    256'(bus.std__mgr__oob_ready), 256'(0));
    check("rst_valid",    256'(pe_valid), 256'(0));
    check("rst_error",    256'(sys_error), 256'(0));
    check("rst_err_code", 256'(sys_err_code), 256'(0));
    check("rst_drop",     256'(sys_drop_cnt), 256'(0));
    check("rst_cmd",      256'(pe_cmd), 256'(0));
    check("rst_num",      256'(pe_num), 256'(0));
    check("rst_opt_type", 256'(pe_opt_type), 256'(0));
    check("rst_opt_val",  256'(pe_opt_value), 256'(0));
    reset_poweron = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 256'(bus.std__mgr__oob_ready), 256'(1));

    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].cntl, vecs[i].typ, vecs[i].data);
      check($sformatf("vec%0d_error", i), 256'(sys_error), 256'(vecs[i].exp_err));
      check($sformatf("vec%0d_code", i),  256'(sys_err_code), 256'(vecs[i].exp_code));
      check($sformatf("vec%0d_drop", i),  256'(sys_drop_cnt), 256'(vecs[i].exp_drop));
      check($sformatf("vec%0d_valid", i), 256'(pe_valid), 256'(0));
    end

    // well-formed 3-tuple record, then back-pressure with a pending manager word
    send(CNTL_SOM, TYPE_CONFIG, 32'h0000_5A03);
    send(CNTL_MOM, TYPE_CONFIG, 32'h0100_0010);
    send(CNTL_MOM, TYPE_CONFIG, 32'h0200_0020);
    send(CNTL_EOM, TYPE_CONFIG, 32'h0300_0030);
    exp_type = 64'h0000_0000_0003_0201;
    exp_val  = '0;
    exp_val[0 +: 24]  = 24'h000010;
    exp_val[24 +: 24] = 24'h000020;
    exp_val[48 +: 24] = 24'h000030;
    check("rec_valid",    256'(pe_valid), 256'(1));
    check("rec_ready",    256'(bus.std__mgr__oob_ready), 256'(0));
    check("rec_cmd",      256'(pe_cmd), 256'(8'h5A));
    check("rec_num",      256'(pe_num), 256'(3));
    check("rec_opt_type", 256'(pe_opt_type), 256'(exp_type));
    check("rec_opt_val",  256'(pe_opt_value), 256'(exp_val));
    check("rec_error",    256'(sys_error), 256'(0));

    bus.mgr__std__oob_cntl  = CNTL_SOM_EOM;
    bus.mgr__std__oob_type  = TYPE_CONFIG;
    bus.mgr__std__oob_data  = 32'h0000_7700;
    bus.mgr__std__oob_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d_valid", c),    256'(pe_valid), 256'(1));
      check($sformatf("bp%0d_ready", c),    256'(bus.std__mgr__oob_ready), 256'(0));
      check($sformatf("bp%0d_cmd", c),      256'(pe_cmd), 256'(8'h5A));
      check($sformatf("bp%0d_num", c),      256'(pe_num), 256'(3));
      check($sformatf("bp%0d_opt_type", c), 256'(pe_opt_type), 256'(exp_type));
    end
    pe_ready = 1'b1;
    @(negedge clk);
    pe_ready = 1'b0;
    check("bp_release_valid", 256'(pe_valid), 256'(0));
    check("bp_release_ready", 256'(bus.std__mgr__oob_ready), 256'(1));
    @(negedge clk);
    bus.mgr__std__oob_valid = 1'b0;
    check("zero_rec_valid",    256'(pe_valid), 256'(1));
    check("zero_rec_cmd",      256'(pe_cmd), 256'(8'h77));
    check("zero_rec_num",      256'(pe_num), 256'(0));
    check("zero_rec_opt_type", 256'(pe_opt_type), 256'(0));
    check("zero_rec_opt_val",  256'(pe_opt_value), 256'(0));
    ack("zero_rec");

    // new SOM while two tuples are held aborts the old packet and starts the new one
    send(CNTL_SOM, TYPE_CONFIG, 32'h0000_3302);
    send(CNTL_MOM, TYPE_CONFIG, 32'h0AAA_AAAA);
    send(CNTL_MOM, TYPE_CONFIG, 32'h0BBB_BBBB);
    send(CNTL_SOM, TYPE_CONFIG, 32'h0000_4401);
    check("abort_error", 256'(sys_error), 256'(1));
    check("abort_code",  256'(sys_err_code), 256'(ERR_ABORT));
    check("abort_drop",  256'(sys_drop_cnt), 256'(6));
    send(CNTL_EOM, TYPE_CONFIG, 32'h0C00_000C);
    check("abort_rec_valid",    256'(pe_valid), 256'(1));
    check("abort_rec_cmd",      256'(pe_cmd), 256'(8'h44));
    check("abort_rec_num",      256'(pe_num), 256'(1));
    check("abort_rec_opt_type", 256'(pe_opt_type), 256'(64'h0C));
    check("abort_rec_opt_val",  256'(pe_opt_value), 256'(192'h00000C));
    check("abort_rec_error",    256'(sys_error), 256'(0));
    ack("abort_rec");

    // reset in the middle of collecting
    send(CNTL_SOM, TYPE_CONFIG, 32'h0000_2202);
    send(CNTL_MOM, TYPE_CONFIG, 32'h0100_0001);
    reset_poweron = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 256'(bus.std__mgr__oob_ready), 256'(0));
    check("mid_rst_drop",  256'(sys_drop_cnt), 256'(0));
    check("mid_rst_code",  256'(sys_err_code), 256'(0));
    check("mid_rst_num",   256'(pe_num), 256'(0));
    check("mid_rst_opt",   256'(pe_opt_type), 256'(0));
    @(negedge clk);
    reset_poweron = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_back", 256'(bus.std__mgr__oob_ready), 256'(1));
    send(CNTL_SOM_EOM, TYPE_CONFIG, 32'h0000_9900);
    check("post_rst_valid", 256'(pe_valid), 256'(1));
    check("post_rst_num",   256'(pe_num), 256'(0));
    check("post_rst_cmd",   256'(pe_cmd), 256'(8'h99));
    check("post_rst_error", 256'(sys_error), 256'(0));
    check("post_rst_code",  256'(sys_err_code), 256'(0));

    // reset while a record is presented drops it
    reset_poweron = 1'b1;
    @(negedge clk);
    check("present_rst_valid", 256'(pe_valid), 256'(0));
    check("present_rst_cmd",   256'(pe_cmd), 256'(0));
    reset_poweron = 1'b0;
    @(negedge clk);

    // drop counter saturation with non-CONFIG single-word packets
    for (int i = 0; i < 260; i++)
      send(CNTL_SOM_EOM, 2'd1, 32'h0000_0000);
    check("drop_saturate", 256'(sys_drop_cnt), 256'(8'hFF));
    check("drop_sat_valid", 256'(pe_valid), 256'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stack_down_oob_rx.md
Name: stack_down_oob_rx

Overview:
- Stack-side receiver for the manager's downstream OOB (out-of-band) channel, i.e. the `mgr__std__oob_*` / `std__mgr__oob_ready` handshake.
- Accepts multi-cycle OOB packets: a header word followed by option-tuple words.
- Assembles each packet into one PE configuration record and presents it to the PE-array configuration logic over a valid/ready port.
- Sits in the stack interface, one instance per manager/PE pair.

Parameters:
- DATA_W, 32, OOB data width. Must match `STACK_DOWN_OOB_INTF_DATA_RANGE`.
- TYPE_W, 2, OOB type width.
- CNTL_W, 2, std-interface cntl width.
- MAX_TUPLES, 8, maximum option tuples per packet.
- OPT_TYPE_W, 8, option type width, taken from data[31:24].
- OPT_VAL_W, 24, option value width, taken from data[23:0].

Ports:
- clk  in  1  clock
- reset_poweron  in  1  synchronous, active-high reset
- mgr__std__oob_cntl  in  CNTL_W  packet delineator
- mgr__std__oob_valid  in  1  word valid
- std__mgr__oob_ready  out  1  receiver can accept a word
- mgr__std__oob_type  in  TYPE_W  packet type; sampled on the header word only
- mgr__std__oob_data  in  DATA_W  header or tuple word
- oob__pe__valid  out  1  configuration record available
- pe__oob__ready  in  1  consumer accepts the record
- oob__pe__cmd  out  8  command from header[15:8]
- oob__pe__num_tuples  out  4  number of tuples received
- oob__pe__opt_type  out  MAX_TUPLES*OPT_TYPE_W  flattened; tuple i at [i*8 +: 8]
- oob__pe__opt_value  out  MAX_TUPLES*OPT_VAL_W  flattened
- oob__sys__error  out  1  one-cycle pulse on a protocol error
- oob__sys__err_code  out  2  held until the next error
- oob__sys__drop_cnt  out  8  count of dropped packets; saturates

Behaviour:
- Transfer: a word moves when mgr__std__oob_valid && std__mgr__oob_ready on a rising clk.
- Cntl encoding (shared package): SOM_EOM=0, SOM=1, MOM=2, EOM=3.
- Header word (SOM or SOM_EOM): data[7:0] = expected tuple count N; data[15:8] = cmd.
- Type values: CONFIG=0. Any other type → packet consumed, not presented, drop_cnt incremented.
- Reset values: all outputs 0. ready=0 during reset and rises the cycle after reset deasserts. Tuple storage is cleared.
- FSM states: IDLE, COLLECT, DISCARD, PRESENT.
- IDLE:
  - SOM + CONFIG → latch cmd and N; clear tuple index; go to COLLECT.
  - SOM_EOM + CONFIG → record with 0 tuples; if N≠0, error code 1 and drop; else go to PRESENT.
  - SOM with non-CONFIG type → DISCARD.
  - MOM or EOM → word dropped, error code 2, stay in IDLE.
- COLLECT:
  - MOM or EOM → write tuple[idx]; idx+1.
  - EOM with received count == N → PRESENT.
  - EOM with count ≠ N → error code 1, drop_cnt+1, back to IDLE.
  - Tuple arriving with idx==MAX_TUPLES → error code 0 (overflow), go to DISCARD.
  - SOM (or SOM_EOM) → abort the current packet with error code 3 and drop_cnt+1; the new word is processed as in IDLE in the same cycle (the new packet starts).
- DISCARD: consume words until EOM, then IDLE. No record is produced.
- PRESENT:
  - oob__pe__valid=1 and ready=0; record fields are held stable.
  - On pe__oob__ready=1 → valid=0 next cycle, ready=1, go to IDLE.
- Latency: EOM accepted at cycle t → valid asserted at t+1. Minimum gap between records is 1 cycle.
- std__mgr__oob_ready is registered and equals (next state != PRESENT).
- Unused tuple slots beyond num_tuples are driven as 0 (cleared on header).
- drop_cnt saturates at 255.
- Reset asserted mid-packet or mid-PRESENT: immediate return to IDLE with all reset values; the partial record is lost and no error is flagged.
- Valid low in any state: no state change.

Decomposition:
- Package stack_down_oob_pkg holds:
  - cntl codes (SOM_EOM/SOM/MOM/EOM);
  - type code CONFIG;
  - error codes OVERFLOW=0, COUNT=1, ORPHAN=2, ABORT=3;
  - header field positions;
  - state encodings.
- One natural sub-module: stack_down_oob_tuple_store. It is a MAX_TUPLES-entry register array with clear, write-enable, index, and flattened read-out.

Test Plan:
- CONFIG packet, header N=3 cmd=0x5A, 3 MOMs then EOM with tuples (0x01,0x000010), (0x02,0x000020), (0x03,0x000030): the EOM is a 4th tuple, so count mismatch → error code 1, drop_cnt=1. Corrected variant: SOM + 2 MOM + EOM, N=3 → valid 1 cycle after EOM, num_tuples=3, cmd=0x5A, slots 3..7 = 0.
- Back-pressure: hold pe__oob__ready=0 for 10 cycles → ready stays 0, record is stable, and manager valid words are not consumed. Release → ready=1 next cycle.
- MOM in IDLE → oob__sys__error pulse, err_code=2, no record produced.
- SOM arrives while COLLECT holds 2 tuples → err_code=3, drop_cnt+1, and the new packet completes normally.
- N=9 header with 9 tuples → overflow on the 9th tuple (err_code 0), remainder discarded until EOM, no record produced.
- Reset pulsed during COLLECT, then a clean SOM_EOM with N=0 → record valid with num_tuples=0 and no error.
